// File: rtl/board_move_sequencer.sv
// board_move_sequencer: chess board state owner with read-check-write move sequencing, overlay mask and flash timing
module board_move_sequencer #(
  parameter int FLASH_COUNT = 25_000_000
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        mv_valid,
  output logic        mv_ready,
  input  logic [5:0]  mv_src,
  input  logic [5:0]  mv_dst,
  input  logic [2:0]  mv_promote,
  input  logic        avail_valid,
  input  logic [63:0] avail_mask,
  input  logic        clear_avail,
  input  logic [5:0]  rd_sq,
  output logic [3:0]  rd_piece,
  output logic        rd_hl,
  output logic        turn,
  output logic        done,
  output logic        err,
  output logic [3:0]  captured
);
  localparam int CW = $clog2(FLASH_COUNT) > 0 ? $clog2(FLASH_COUNT) : 1;
  localparam logic [CW-1:0] FLAST = CW'(FLASH_COUNT - 1);
  localparam logic [2:0] IDLE = 3'd0, RD_SRC = 3'd1, RD_DST = 3'd2, CHECK = 3'd3,
                         WR_DST = 3'd4, WR_SRC = 3'd5, REJECT = 3'd6;
  localparam logic [2:0] BACK [8] = '{3'd4, 3'd3, 3'd2, 3'd6, 3'd5, 3'd2, 3'd3, 3'd4};
  logic [2:0]    state, state_nx;
  logic [3:0]    board [64];
  logic [5:0]    src_q, dst_q;
  logic [2:0]    prom_q;
  logic [3:0]    src_p, dst_p, wr_p;
  logic [63:0]   mask;
  logic          flash, bad, promo;
  logic [CW-1:0] fcnt;
  function automatic logic [3:0] init_sq(input logic [5:0] sq);
    return sq[5:3] == 3'd0 ? {1'b1, BACK[sq[2:0]]} :
           sq[5:3] == 3'd1 ? 4'b1001 :
           sq[5:3] == 3'd6 ? 4'b0001 :
           sq[5:3] == 3'd7 ? {1'b0, BACK[sq[2:0]]} : 4'b0000;
  endfunction
  assign mv_ready = state == IDLE;
  assign done     = state == WR_SRC;
  assign err      = state == REJECT;
  always_comb begin
    bad = src_p[2:0] == 3'd0 || src_p[3] != turn || src_q == dst_q ||
          (dst_p != 4'd0 && dst_p[3] == src_p[3]);
    promo = src_p[2:0] == 3'd1 && dst_q[5:3] == (src_p[3] ? 3'd7 : 3'd0);
    wr_p = promo ? {src_p[3], (prom_q >= 3'd2 && prom_q <= 3'd5) ? prom_q : 3'd5} : src_p;
    state_nx = state == IDLE   ? (mv_valid ? RD_SRC : IDLE) :
               state == RD_SRC ? RD_DST :
               state == RD_DST ? CHECK :
               state == CHECK  ? (bad ? REJECT : WR_DST) :
               state == WR_DST ? WR_SRC : IDLE;
  end
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      for (int i = 0; i < 64; i++) board[i] <= init_sq(6'(i));
      state    <= IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      prom_q   <= '0;
      src_p    <= '0;
      dst_p    <= '0;
      mask     <= '0;
      flash    <= 1'b0;
      fcnt     <= '0;
      turn     <= 1'b0;
      captured <= '0;
      rd_piece <= '0;
      rd_hl    <= 1'b0;
    end else begin
      state <= state_nx;
      if (mv_valid && mv_ready) begin
        src_q  <= mv_src;
        dst_q  <= mv_dst;
        prom_q <= mv_promote;
      end
      if (state == RD_SRC) src_p <= board[src_q];
      if (state == RD_DST) dst_p <= board[dst_q];
      if (state == WR_DST) begin
        board[dst_q] <= wr_p;
        captured     <= dst_p;
      end
      if (state == WR_SRC) begin
        board[src_q] <= 4'd0;
        turn         <= ~turn;
      end
      mask     <= (state == WR_SRC || clear_avail) ? '0 : avail_valid ? avail_mask : mask;
      fcnt     <= fcnt == FLAST ? '0 : fcnt + 1'b1;
      flash    <= flash ^ (fcnt == FLAST);
      rd_piece <= board[rd_sq];
      rd_hl    <= mask[rd_sq] & flash;
    end
endmodule

// File: doc/board_move_sequencer.md
Name: board_move_sequencer

Overview:
- Owns the 64-square chess board state and sequences every move into it as a multi-cycle read-check-write transaction.
- Tracks side-to-move, holds the available-move overlay mask and generates the overlay flash timing.
- Serves a registered read port so the OLED renderer can fetch any square's piece code each cycle.
- Sits between the game/cursor logic (move requester) and the board renderer.

Parameters:
- FLASH_COUNT, 25_000_000, clock cycles per flash half-period (flash toggles every FLASH_COUNT cycles).

Ports:
- clock  in  1  system clock
- resetn  in  1  reset
- mv_valid  in  1  move request valid
- mv_ready  out  1  sequencer can accept a move
- mv_src  in  6  source square index (y*8+x)
- mv_dst  in  6  destination square index
- mv_promote  in  3  promotion piece type
- avail_valid  in  1  load avail_mask into the overlay register
- avail_mask  in  64  bit n set = square n is a legal target
- clear_avail  in  1  clear the overlay register
- rd_sq  in  6  renderer square index
- rd_piece  out  4  {colour, type} of square rd_sq
- rd_hl  out  1  square rd_sq is highlighted this flash phase
- turn  out  1  side to move (0 white, 1 black)
- done  out  1  one-cycle pulse: move committed
- err  out  1  one-cycle pulse: move rejected
- captured  out  4  piece code removed from mv_dst by the last committed move

Behaviour:
- Reset: one clock; resetn is asynchronous, active-low.
- Reset values:
  - board = initial position: 0..7 = black R,N,B,K,Q,B,N,R; 8..15 = black pawns; 16..47 = 4'b0000; 48..55 = white pawns; 56..63 = white R,N,B,K,Q,B,N,R.
  - Outputs: mv_ready=1, rd_piece=0, rd_hl=0, turn=0, done=0, err=0, captured=0.
  - Internal: overlay mask=0, flash=0, flash counter=0, FSM=IDLE.
- Piece encoding: bit3 = colour (0 white, 1 black); bits2:0 = EMPTY 0, PAWN 1, BISHOP 2, KNIGHT 3, ROOK 4, QUEEN 5, KING 6.
  - An empty square is 4'b0000.
- Handshake:
  - A move is accepted on a cycle where mv_valid and mv_ready are both 1.
  - mv_src, mv_dst and mv_promote are latched on that cycle.
  - mv_ready is 1 only in IDLE.
- FSM: IDLE -> RD_SRC -> RD_DST -> CHECK -> WR_DST -> WR_SRC -> IDLE.
  - CHECK goes to REJECT instead of WR_DST on failure; REJECT -> IDLE.
- CHECK fails if any of:
  - src piece is EMPTY
  - src colour != turn
  - src == dst
  - dst is non-empty with the same colour as src
- Latency: acceptance on cycle T.
  - Commit: done pulses in cycle T+5 (the WR_SRC cycle).
  - Reject: err pulses in cycle T+4 (the REJECT cycle).
- WR_DST:
  - board[dst] <= moved piece; captured <= old board[dst] (0 if empty).
  - Promotion: if the moved piece is a PAWN and dst row is 0 (white) or 7 (black), write {colour, mv_promote} when mv_promote is 2..5; any other value writes QUEEN.
- WR_SRC: board[src] <= 0; turn toggles; the overlay mask clears.
- Reject: board, turn and captured are unchanged.
- No legality checking beyond CHECK (movement geometry, check, castling and en passant are the requester's job).
- Overlay mask:
  - avail_valid loads avail_mask in any state.
  - clear_avail clears the mask.
  - Same-cycle clear_avail and avail_valid: clear wins.
  - A commit clear in WR_SRC overrides a same-cycle load.
- Flash:
  - The counter runs 0..FLASH_COUNT-1 and wraps to 0.
  - flash toggles on the wrap cycle.
- Read port:
  - rd_piece and rd_hl are registered with 1-cycle latency from rd_sq: rd_piece = board[rd_sq]; rd_hl = mask[rd_sq] & flash.
  - A read of a square written in the same cycle returns the old value.
- Reset asserted mid-transaction: asynchronously returns every item to its reset value.
  - No partial move persists.
  - No done or err pulse is emitted.

Test Plan:
- After reset, sweep rd_sq 0..63 -> rd_piece[0]=4'b1100, [3]=4'b1110, [8]=4'b1001, [20]=0, [52]=4'b0001, [59]=4'b0110; turn=0; mv_ready=1.
- Move src=52 dst=36 accepted at T -> mv_ready=0 during T+1..T+5, done at T+5, board[36]=4'b0001, board[52]=0, turn=1, captured=0.
- From reset, move src=12 dst=28 (black piece on white's turn) -> err at T+4; board unchanged; turn=0. Repeat with src=20 (empty) and with src=dst=52 -> err each time.
- Capture and promotion:
  - Preload a position with a black knight on 20; white pawn 52->20 -> captured=4'b1011.
  - White pawn 8->0 with mv_promote=3 -> board[0]=4'b0011.
  - Same move with mv_promote=7 -> board[0]=4'b0101.
- FLASH_COUNT=4:
  - Load mask bit 36 -> rd_sq=36 gives rd_hl toggling every 4 cycles.
  - Same-cycle avail_valid+clear_avail -> mask stays 0.
  - A committed move clears the mask.
- Assert resetn low at T+3 of a move -> board returns to initial, turn=0, mv_ready=1, no done pulse.
